alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered successor to the single-cycle execution-stage ALU. Keeps opcodes 0-9 and adds iterative signed/unsigned multiply and divide with a HI/LO result pair. Adds a valid/ready handshake and overflow and divide-by-zero flags. Sits in the execute stage; the pipeline control stalls on i_ready low.

Parameters:
BUS_WIDTH, 32, operand/result width; must be a power of 2, >= 8
OP_BITS, 4, opcode width; codes 0-13 defined, remaining codes reserved

Ports:
clk  in  1  single clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high; clears all state
i_valid  in  1  operation request; sampled when i_ready=1
i_ready  out  1  combinational; 1 only in state IDLE
A  in  BUS_WIDTH  operand A (signed for signed ops)
B  in  BUS_WIDTH  operand B; for shifts only B[$clog2(BUS_WIDTH)-1:0] used
OPCODE  in  OP_BITS  operation select
RESULT_OUT  out  BUS_WIDTH  registered result (LO for mul/div)
RESULT_HI  out  BUS_WIDTH  registered HI (mul upper half / div remainder); 0 for ops 0-9
zero_flag  out  1  registered, see Behaviour
overflow_flag  out  1  registered signed overflow
div_by_zero  out  1  registered, set for DIV/DIVU with B=0
o_valid  out  1  one-cycle pulse: outputs updated this cycle

Behaviour:
- Reset (async, any time): state=IDLE, all outputs 0 except i_ready=1. Iteration registers cleared. An in-flight op is aborted and no o_valid is produced.
- Accept: i_valid && i_ready at a rising edge latches A, B and OPCODE. Inputs are ignored at all other times.
- Opcodes 0-9 and reserved codes (latency 1): outputs are registered at the accepting edge, so o_valid=1 in the next cycle. State stays IDLE, so back-to-back issue runs at 1 op/cycle.
  - 0 SLL: A << sh
  - 1 SRL: logical A >> sh
  - 2 SRA: arithmetic A >>> sh
  - 3 ADD: A+B; overflow_flag=1 if signed overflow
  - 4 AND; 5 OR; 6 XOR; 7 NOR
  - 8 SUB: A-B; overflow_flag on signed overflow
  - 9 SLT: signed A<B gives 1, else 0
  - 14-15: RESULT_OUT=0
- zero_flag: for 8 and 9, zero_flag = (A==B). For all other ops, zero_flag = ({RESULT_HI,RESULT_OUT}==0).
- overflow_flag and div_by_zero are 0 unless stated.
- 10 MUL (signed), 11 MULU: the accepting edge moves state IDLE->MUL. The block runs BUS_WIDTH shift-add iterations on operand magnitudes (signed: |A|,|B|), one per cycle. On the final iteration edge it negates the 2*BUS_WIDTH product if the signs differ (signed only), writes {RESULT_HI,RESULT_OUT} and returns to IDLE.
  - o_valid is asserted exactly BUS_WIDTH cycles after the accept cycle.
  - i_ready=0 during MUL; i_ready=1 in the o_valid cycle, so the next op may be accepted then.
- 12 DIV (signed), 13 DIVU: same structure via IDLE->DIV, BUS_WIDTH restoring-division iterations on magnitudes.
  - Quotient goes to RESULT_OUT and truncates toward zero.
  - Remainder goes to RESULT_HI and takes the sign of A.
  - Latency is identical to MUL.
- B=0 for DIV/DIVU: no iteration, latency 1. RESULT_OUT = all ones, RESULT_HI = A, div_by_zero=1.
- DIV with A = most-negative and B = -1: RESULT_OUT = most-negative, RESULT_HI=0, overflow_flag=1. This is still computed iteratively, with normal latency.
- Outputs and flags hold their values between o_valid pulses. Nothing changes while busy.
- State machine: IDLE, MUL and DIV. The iteration counter is $clog2(BUS_WIDTH)+1 bits, loaded at accept and counting down to 0; the finalize happens on the edge where the count is 1.

Test Plan:
- ADD overflow: A=0x7FFFFFFF, B=1, OP=3 -> next cycle RESULT_OUT=0x80000000, overflow_flag=1, zero_flag=0, o_valid=1 for exactly 1 cycle.
- SRA and shift masking: A=0x80000000, B=0x21, OP=2 -> RESULT_OUT=0xC0000000. Then SUB with A=B=5 -> RESULT_OUT=0, zero_flag=1.
- Signed MUL: A=0xFFFFFFFD (-3), B=7, OP=10 -> i_ready=0 for 31 cycles, then o_valid on cycle 32 after accept with RESULT_HI=0xFFFFFFFF, RESULT_OUT=0xFFFFFFEB. Repeat with OP=11 -> RESULT_HI=0x00000006, RESULT_OUT=0xFFFFFFEB.
- Signed DIV: A=-7, B=2, OP=12 -> RESULT_OUT=0xFFFFFFFD, RESULT_HI=0xFFFFFFFF. Then A=0x80000000, B=0xFFFFFFFF -> RESULT_OUT=0x80000000, RESULT_HI=0, overflow_flag=1.
- DIVU by zero: A=5, B=0, OP=13 -> 1-cycle latency, RESULT_OUT=0xFFFFFFFF, RESULT_HI=5, div_by_zero=1. Issue ADD in the o_valid cycle and check it is accepted back-to-back.
- Reset abort: assert reset 10 cycles into a MUL -> outputs 0 immediately, i_ready=1, no o_valid follows. A subsequent AND 0xF0F0 & 0xFF00 returns 0xF000.

Source files
------------

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle logic/shift/arith ops plus iterative
// signed/unsigned multiply and restoring divide producing a HI/LO pair.
module alu_seq #(
  parameter int BUS_WIDTH = 32,
  parameter int OP_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [BUS_WIDTH-1:0] A,
  input  logic [BUS_WIDTH-1:0] B,
  input  logic [OP_BITS-1:0]   OPCODE,
  output logic [BUS_WIDTH-1:0] RESULT_OUT,
  output logic [BUS_WIDTH-1:0] RESULT_HI,
  output logic                 zero_flag,
  output logic                 overflow_flag,
  output logic                 div_by_zero,
  output logic                 o_valid
);

  localparam int W   = BUS_WIDTH;
  localparam int SHW = $clog2(W);
  localparam int CW  = SHW + 1;

  localparam logic [OP_BITS-1:0] OP_SLL  = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_SRL  = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_SRA  = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_ADD  = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OP_AND  = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_OR   = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] OP_XOR  = OP_BITS'(6);
  localparam logic [OP_BITS-1:0] OP_NOR  = OP_BITS'(7);
  localparam logic [OP_BITS-1:0] OP_SUB  = OP_BITS'(8);
  localparam logic [OP_BITS-1:0] OP_SLT  = OP_BITS'(9);
  localparam logic [OP_BITS-1:0] OP_MUL  = OP_BITS'(10);
  localparam logic [OP_BITS-1:0] OP_MULU = OP_BITS'(11);
  localparam logic [OP_BITS-1:0] OP_DIV  = OP_BITS'(12);
  localparam logic [OP_BITS-1:0] OP_DIVU = OP_BITS'(13);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         ovf;
    logic         dbz;
  } res_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic          neg_q, neg_d, rneg_q, rneg_d, ovf_q, ovf_d;
  res_t          res_q, res_d;
  logic          vld_q, vld_d;

  logic          is_mul_op, is_div_op, sgn_op, div_mode;
  logic [W-1:0]  abs_a, abs_b, op_a, op_b;
  logic [W-1:0]  s_hi, s_lo, s_m;
  logic [W:0]    mul_sum;
  logic [W-1:0]  mul_hi, mul_lo;
  logic [W:0]    div_sh;
  logic [W-1:0]  div_sub, div_hi, div_lo;
  logic          div_ge;
  logic [2*W-1:0] prod_f;
  logic [W-1:0]  quo_f, rem_f;
  logic [SHW-1:0] sh;
  logic [W-1:0]  sum, diff;
  res_t          alu_res;

  assign i_ready   = (state_q == IDLE);
  assign is_mul_op = (OPCODE == OP_MUL) || (OPCODE == OP_MULU);
  assign is_div_op = (OPCODE == OP_DIV) || (OPCODE == OP_DIVU);
  assign sgn_op    = (OPCODE == OP_MUL) || (OPCODE == OP_DIV);
  assign abs_a     = A[W-1] ? -A : A;
  assign abs_b     = B[W-1] ? -B : B;
  assign op_a      = sgn_op ? abs_a : A;
  assign op_b      = sgn_op ? abs_b : B;

  // The accept edge performs the first iteration on fresh operands, so the
  // busy phase only needs W-1 further edges.
  always_comb begin
    if (state_q == IDLE) begin
      div_mode = is_div_op;
      s_hi     = '0;
      s_lo     = is_div_op ? op_a : op_b;
      s_m      = is_div_op ? op_b : op_a;
    end else begin
      div_mode = (state_q == DIV);
      s_hi     = hi_q;
      s_lo     = lo_q;
      s_m      = m_q;
    end
  end

  // Shift-add multiply step: HI accumulates, LO shifts out multiplier bits.
  assign mul_sum = {1'b0, s_hi} + (s_lo[0] ? {1'b0, s_m} : {(W+1){1'b0}});
  assign mul_hi  = mul_sum[W:1];
  assign mul_lo  = {mul_sum[0], s_lo[W-1:1]};

  // Restoring divide step: HI is the partial remainder, LO shifts dividend
  // bits out and quotient bits in.
  assign div_sh  = {s_hi, s_lo[W-1]};
  assign div_ge  = (div_sh >= {1'b0, s_m});
  assign div_sub = div_sh[W-1:0] - s_m;
  assign div_hi  = div_ge ? div_sub : div_sh[W-1:0];
  assign div_lo  = {s_lo[W-2:0], div_ge};

  assign prod_f = neg_q  ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
  assign quo_f  = neg_q  ? -div_lo : div_lo;
  assign rem_f  = rneg_q ? -div_hi : div_hi;

  assign sh   = B[SHW-1:0];
  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    alu_res = '0;
    unique case (OPCODE)
      OP_SLL: alu_res.lo = A << sh;
      OP_SRL: alu_res.lo = A >> sh;
      OP_SRA: alu_res.lo = W'($signed(A) >>> sh);
      OP_ADD: begin
        alu_res.lo  = sum;
        alu_res.ovf = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      OP_AND: alu_res.lo = A & B;
      OP_OR:  alu_res.lo = A | B;
      OP_XOR: alu_res.lo = A ^ B;
      OP_NOR: alu_res.lo = ~(A | B);
      OP_SUB: begin
        alu_res.lo  = diff;
        alu_res.ovf = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
      end
      OP_SLT: alu_res.lo = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
      // Only reached with B == 0; non-zero divisors go through the iterative path.
      OP_DIV, OP_DIVU: begin
        alu_res.lo  = '1;
        alu_res.hi  = A;
        alu_res.dbz = 1'b1;
      end
      default: ;
    endcase
    if (OPCODE == OP_SUB || OPCODE == OP_SLT) alu_res.zero = (A == B);
    else                                      alu_res.zero = ({alu_res.hi, alu_res.lo} == '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (is_mul_op || (is_div_op && B != '0)) begin
            state_d = is_mul_op ? MUL : DIV;
            cnt_d   = CW'(W - 1);
            hi_d    = div_mode ? div_hi : mul_hi;
            lo_d    = div_mode ? div_lo : mul_lo;
            m_d     = s_m;
            neg_d   = sgn_op && (A[W-1] ^ B[W-1]);
            rneg_d  = sgn_op && A[W-1];
            ovf_d   = (OPCODE == OP_DIV) && (A == MOST_NEG) && (B == '1);
          end else begin
            res_d = alu_res;
            vld_d = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        hi_d  = div_mode ? div_hi : mul_hi;
        lo_d  = div_mode ? div_lo : mul_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          vld_d   = 1'b1;
          res_d   = '0;
          if (state_q == MUL) begin
            res_d.hi   = prod_f[2*W-1:W];
            res_d.lo   = prod_f[W-1:0];
            res_d.zero = (prod_f == '0);
          end else begin
            res_d.hi   = rem_f;
            res_d.lo   = quo_f;
            res_d.ovf  = ovf_q;
            res_d.zero = ({rem_f, quo_f} == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  assign RESULT_OUT    = res_q.lo;
  assign RESULT_HI     = res_q.hi;
  assign zero_flag     = res_q.zero;
  assign overflow_flag = res_q.ovf;
  assign div_by_zero   = res_q.dbz;
  assign o_valid       = vld_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expectations are queued at issue and checked
// (value, flags, latency, busy cycles) when o_valid fires.
module tb_alu_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [W-1:0]  A = '0, B = '0;
  logic [3:0]    OPCODE = '0;
  logic [W-1:0]  RESULT_OUT, RESULT_HI;
  logic          zero_flag, overflow_flag, div_by_zero, o_valid;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         ov;
    logic         dz;
    int           lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq #(.BUS_WIDTH(W), .OP_BITS(4)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
    .A(A), .B(B), .OPCODE(OPCODE),
    .RESULT_OUT(RESULT_OUT), .RESULT_HI(RESULT_HI),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag),
    .div_by_zero(div_by_zero), .o_valid(o_valid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_res(input logic [W-1:0] lo, input logic [W-1:0] hi,
                            input logic z, input logic ov, input logic dz, input int lat);
    exp_t e;
    e.lo = lo; e.hi = hi; e.z = z; e.ov = ov; e.dz = dz; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    i_valid = 1'b1; A = a; B = b; OPCODE = op;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    int n = 0;
    int busy = 0;
    exp_t e;
    do begin
      @(negedge clk);
      n++;
      if (!o_valid && !i_ready) busy++;
    end while (!o_valid && n < 200);
    e = sb.pop_front();
    chk({tag, ".lat"},  64'(n),    64'(e.lat));
    chk({tag, ".busy"}, 64'(busy), 64'(e.lat - 1));
    chk({tag, ".lo"},   64'(RESULT_OUT),    64'(e.lo));
    chk({tag, ".hi"},   64'(RESULT_HI),     64'(e.hi));
    chk({tag, ".zero"}, 64'(zero_flag),     64'(e.z));
    chk({tag, ".ovf"},  64'(overflow_flag), 64'(e.ov));
    chk({tag, ".dbz"},  64'(div_by_zero),   64'(e.dz));
  endtask

  initial begin
    int vcount;
    #12;
    chk("rst.ready", 64'(i_ready), 64'd1);
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.lo",    64'(RESULT_OUT), 64'd0);
    chk("rst.hi",    64'(RESULT_HI), 64'd0);
    chk("rst.flags", 64'({zero_flag, overflow_flag, div_by_zero}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    expect_res(32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1);
    issue(32'h7FFF_FFFF, 32'h1, 4'd3);
    collect("add_ovf");
    @(negedge clk);
    chk("add_ovf.pulse", 64'(o_valid), 64'd0);
    chk("add_ovf.hold",  64'(RESULT_OUT), 64'h8000_0000);

    expect_res(32'hC000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    issue(32'h8000_0000, 32'h21, 4'd2);
    collect("sra");

    expect_res(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    issue(32'd5, 32'd5, 4'd8);
    collect("sub_eq");

    expect_res(32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    issue(32'hFFFF_FFFF, 32'h1, 4'd9);
    collect("slt_neg");

    expect_res(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    issue(32'd3, 32'd3, 4'd9);
    collect("slt_eq");

    expect_res(32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32);
    issue(32'hFFFF_FFFD, 32'd7, 4'd10);
    collect("mul");

    expect_res(32'hFFFF_FFEB, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 32);
    issue(32'hFFFF_FFFD, 32'd7, 4'd11);
    collect("mulu");

    expect_res(32'd20, 32'h0, 1'b0, 1'b0, 1'b0, 32);
    issue(32'hFFFF_FFFC, 32'hFFFF_FFFB, 4'd10);
    collect("mul_negneg");

    expect_res(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32);
    issue(32'hFFFF_FFF9, 32'd2, 4'd12);
    collect("div");

    expect_res(32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 32);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 4'd12);
    collect("div_ovf");

    expect_res(32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 32);
    issue(32'd100, 32'd7, 4'd13);
    collect("divu");

    expect_res(32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 1'b1, 1);
    issue(32'd5, 32'd0, 4'd13);
    collect("divu_dbz");
    chk("b2b.ready", 64'(i_ready), 64'd1);
    expect_res(32'd5, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    issue(32'd2, 32'd3, 4'd3);
    collect("b2b_add");

    expect_res(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    issue(32'h1234, 32'h5678, 4'd14);
    collect("reserved");

    expect_res(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    issue(32'h0, 32'h0, 4'd7);
    collect("nor");

    issue(32'd9, 32'd9, 4'd11);
    repeat (10) @(negedge clk);
    chk("abort.busy", 64'(i_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("abort.ready", 64'(i_ready), 64'd1);
    chk("abort.lo",    64'(RESULT_OUT), 64'd0);
    chk("abort.hi",    64'(RESULT_HI), 64'd0);
    chk("abort.valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) vcount++;
    end
    chk("abort.no_valid", 64'(vcount), 64'd0);

    expect_res(32'h0000_F000, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    issue(32'h0000_F0F0, 32'h0000_FF00, 4'd4);
    collect("and");

    chk("sb.empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
